// File: rtl/sar_sample_buffer_pkg.sv
// Shared ADC constants: frame length and frame-counter width used by both
// sar_logic and the sample buffer, so the two counters stay in lock-step.
package sar_sample_buffer_pkg;

  // One conversion frame: PRECISION bit trials plus sample and load cycles.
  function automatic int frame_len(input int precision);
    return precision + 2;
  endfunction

  // Width of a counter stepping 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_fifo.sv
// Show-ahead FIFO; the head is read combinationally from the storage array.
// Full/empty come from an extra pointer MSB.
module sar_fifo
  import sar_sample_buffer_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO only lands when a pop frees the slot on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sar_sample_buffer.sv
// Captures finished SAR conversions once per frame, averages 2^OSR_LOG2 of
// them and queues the results in a show-ahead FIFO with a sticky overflow flag.
module sar_sample_buffer
  import sar_sample_buffer_pkg::*;
#(
  parameter int PRECISION = 10,
  parameter int OSR_LOG2  = 2,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRECISION-1:0] sar_in,
  input  logic                 enable,
  output logic [PRECISION-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int FRAME = frame_len(PRECISION);
  localparam int FCW   = cnt_width(FRAME);
  localparam int ACW   = PRECISION + OSR_LOG2;
  localparam int OCW   = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAME - 1);
  // With OSR_LOG2=0 this is 0, so every sample closes its own group.
  localparam logic [OCW-1:0] OCNT_LAST = OCW'((1 << OSR_LOG2) - 1);

  logic [FCW-1:0]       r_fcnt;
  logic                 r_first_done;
  logic [ACW-1:0]       r_acc;
  logic [OCW-1:0]       r_ocnt;
  logic                 r_overflow;
  logic                 w_sample;
  logic                 w_last;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [ACW-1:0]       w_sum;
  logic [PRECISION-1:0] w_avg;

  // sar_in only holds a finished result at fcnt==0, and not before a full frame has run.
  assign w_sample = (r_fcnt == '0) && r_first_done;
  assign w_last   = (r_ocnt == OCNT_LAST);
  assign w_sum    = r_acc + ACW'(sar_in);
  assign w_avg    = PRECISION'(w_sum >> OSR_LOG2);
  assign w_push   = enable && w_sample && w_last;
  assign w_pop    = out_valid && out_ready;
  assign w_drop   = w_push && w_full && !w_pop;

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt       <= '0;
      r_first_done <= 1'b0;
    end else if (r_fcnt == FCNT_LAST) begin
      r_fcnt       <= '0;
      r_first_done <= 1'b1;
    end else begin
      r_fcnt       <= r_fcnt + FCW'(1);
      r_first_done <= r_first_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_acc  <= '0;
      r_ocnt <= '0;
    end else if (w_sample) begin
      if (w_last) begin
        r_acc  <= '0;
        r_ocnt <= '0;
      end else begin
        r_acc  <= w_sum;
        r_ocnt <= r_ocnt + OCW'(1);
      end
    end
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  sar_fifo #(
    .WIDTH (PRECISION),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_avg),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
